// File: rtl/qlab5_sys_mem_test_master.sv
// Avalon-MM memory self-test initiator: writes seed+i over a word window, reads it
// back and counts words whose readdata differs from the written pattern.
module qlab5_sys_mem_test_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       length,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       error_count,
  output logic [ADDR_W-1:0]     first_error_addr,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W/8-1:0]   byteenable,
  output logic                  chipselect,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  input  logic [DATA_W-1:0]     readdata,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic [DATA_W-1:0]   pat_q, pat_d;
  logic                cs_q, cs_d;
  logic                write_q, write_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Each issued read carries its address and expected word down a delay line that
  // lines up with the slave's read latency.
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
  logic [ADDR_W-1:0]       pipe_addr_d [READ_LATENCY];
  logic [DATA_W-1:0]       pipe_pat_q  [READ_LATENCY];
  logic [DATA_W-1:0]       pipe_pat_d  [READ_LATENCY];

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    pat_d       = pat_q;
    cs_d        = cs_q;
    write_d     = write_q;
    err_d       = err_q;
    first_d     = first_q;
    cnt_d       = cnt_q;

    pipe_vld_d[0]  = cs_q & ~write_q;
    pipe_addr_d[0] = address_q;
    pipe_pat_d[0]  = pat_q;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_addr_d[k] = pipe_addr_q[k-1];
      pipe_pat_d[k]  = pipe_pat_q[k-1];
    end

    if (pipe_vld_q[READ_LATENCY-1] && (readdata != pipe_pat_q[READ_LATENCY-1])) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) first_d = pipe_addr_q[READ_LATENCY-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base;
          len_d   = length;
          seed_d  = seed;
          err_d   = '0;
          first_d = '0;
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_WRITE;
            cs_d        = 1'b1;
            write_d     = 1'b1;
            address_d   = base;
            writedata_d = seed;
            pat_d       = seed;
            idx_d       = (ADDR_W+1)'(1);
          end
        end
      end
      S_WRITE: begin
        if (idx_q == len_q) begin
          // Straight into the read phase so the bus never idles between phases.
          state_d     = S_READ;
          write_d     = 1'b0;
          address_d   = base_q;
          writedata_d = '0;
          pat_d       = seed_q;
          idx_d       = (ADDR_W+1)'(1);
        end else begin
          address_d   = base_q + idx_q[ADDR_W-1:0];
          writedata_d = seed_q + DATA_W'(idx_q);
          pat_d       = seed_q + DATA_W'(idx_q);
          idx_d       = idx_q + 1'b1;
        end
      end
      S_READ: begin
        if (idx_q == len_q) begin
          state_d = S_DRAIN;
          cs_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          address_d = base_q + idx_q[ADDR_W-1:0];
          pat_d     = seed_q + DATA_W'(idx_q);
          idx_d     = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(READ_LATENCY-1)) state_d = S_DONE;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      address_q   <= '0;
      writedata_q <= '0;
      pat_q       <= '0;
      cs_q        <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
      cnt_q       <= '0;
      pipe_vld_q  <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_addr_q[k] <= '0;
        pipe_pat_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      pat_q       <= pat_d;
      cs_q        <= cs_d;
      write_q     <= write_d;
      err_q       <= err_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      pipe_vld_q  <= pipe_vld_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_addr_q[k] <= pipe_addr_d[k];
        pipe_pat_q[k]  <= pipe_pat_d[k];
      end
    end
  end

  assign busy             = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done             = (state_q == S_DONE);
  assign error_count      = err_q;
  assign first_error_addr = first_q;
  assign address          = address_q;
  assign byteenable       = '1;
  assign chipselect       = cs_q;
  assign write            = write_q;
  assign writedata        = writedata_q;
  assign dbg_state        = state_q;

endmodule
